keypad_scanner: RTL and testbench

- Parametrised ROWS x COLS matrix-keypad scanner. Successor to the fixed 4x4 scanner.
- Adds: programmable column dwell, row-input synchroniser, press/release debounce, multi-key (ghost) rejection, single-cycle key events and optional auto-repeat.
- Sits between the keypad pins and the vending-machine control FSM. The control FSM consumes key_valid/key_code pulses instead of a level code.

---
 rtl/keypad_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWS x COLS matrix keypad scanner with row synchroniser,
// press/release debounce, ghost rejection, key events and auto-repeat.
module keypad_scanner #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DEBOUNCE    = 20,
    parameter int REPEAT_DLY  = 0,
    parameter int REPEAT_RATE = 100,
    localparam int KEY_W      = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic             key_release
);
    localparam int PW  = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(DEBOUNCE + 1);
    localparam int RMX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW  = $clog2(RMX + 1);
    localparam int CW  = $clog2(COLS);
    localparam int RIW = $clog2(ROWS);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

    state_t            state, state_n;
    logic [ROWS-1:0]   sync1, rs;
    logic [PW-1:0]     pcnt;
    logic              tick;
    logic [CW-1:0]     cidx, cidx_n, cidx_rot;
    logic [DW-1:0]     deb, deb_n;
    logic [RW-1:0]     rep, rep_n;
    logic              rfst, rfst_n;
    logic [ROWS-1:0]   cap_pat, pat_n;
    logic [KEY_W-1:0]  cap_code, ccode_n, code_n, fresh;
    logic              valid_n, held_n, rel_n;
    logic [ROWS-1:0]   zmask;
    logic              one_zero, all_ones;
    logic [RIW-1:0]    ridx;
    int                lim;

    assign col      = ~(COLS'(1) << cidx);
    assign tick     = (pcnt == PW'(SCAN_DIV - 1));
    assign zmask    = ~rs;
    assign one_zero = (zmask != '0) && ((zmask & (zmask - ROWS'(1))) == '0);
    assign all_ones = &rs;
    assign cidx_rot = (cidx == CW'(COLS - 1)) ? '0 : cidx + CW'(1);
    assign fresh    = KEY_W'(int'(cidx) * ROWS + int'(ridx));

    // two-flop synchroniser on the pulled-up row inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            rs    <= '1;
        end else begin
            sync1 <= row;
            rs    <= sync1;
        end
    end

    // free-running prescaler producing the scan tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + PW'(1);
    end

    // position of the single pulled-low row
    always_comb begin
        ridx = '0;
        for (int i = 0; i < ROWS; i++)
            if (!rs[i]) ridx = RIW'(i);
    end

    // scanner state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SCAN;
            cidx        <= '0;
            deb         <= '0;
            rep         <= '0;
            rfst        <= 1'b1;
            cap_pat     <= '1;
            cap_code    <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            cidx        <= cidx_n;
            deb         <= deb_n;
            rep         <= rep_n;
            rfst        <= rfst_n;
            cap_pat     <= pat_n;
            cap_code    <= ccode_n;
            key_code    <= code_n;
            key_valid   <= valid_n;
            key_held    <= held_n;
            key_release <= rel_n;
        end
    end

    // next-state, counters and event generation, evaluated on ticks
    always_comb begin
        state_n = state;
        cidx_n  = cidx;
        deb_n   = deb;
        rep_n   = rep;
        rfst_n  = rfst;
        pat_n   = cap_pat;
        ccode_n = cap_code;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
        rel_n   = 1'b0;
        lim     = rfst ? REPEAT_DLY : REPEAT_RATE;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (one_zero) begin
                        pat_n   = rs;
                        ccode_n = fresh;
                        deb_n   = DW'(1);
                        if (DEBOUNCE == 1) begin
                            state_n = PRESSED;
                            code_n  = fresh;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            rep_n   = '0;
                            rfst_n  = 1'b1;
                            deb_n   = '0;
                        end else begin
                            state_n = DEB_PRESS;
                        end
                    end else begin
                        cidx_n = cidx_rot;
                    end
                end
                DEB_PRESS: begin
                    if (rs == cap_pat) begin
                        if (deb == DW'(DEBOUNCE - 1)) begin
                            state_n = PRESSED;
                            code_n  = cap_code;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            rep_n   = '0;
                            rfst_n  = 1'b1;
                            deb_n   = '0;
                        end else begin
                            deb_n = deb + DW'(1);
                        end
                    end else begin
                        deb_n   = '0;
                        cidx_n  = cidx_rot;
                        state_n = SCAN;
                    end
                end
                PRESSED: begin
                    if (all_ones) begin
                        if (DEBOUNCE == 1) begin
                            rel_n   = 1'b1;
                            held_n  = 1'b0;
                            cidx_n  = cidx_rot;
                            deb_n   = '0;
                            state_n = SCAN;
                        end else begin
                            deb_n   = DW'(1);
                            state_n = DEB_REL;
                        end
                    end else if (REPEAT_DLY > 0) begin
                        if (int'(rep) + 1 == lim) begin
                            valid_n = 1'b1;
                            rep_n   = '0;
                            rfst_n  = 1'b0;
                        end else begin
                            rep_n = rep + RW'(1);
                        end
                    end
                end
                DEB_REL: begin
                    if (all_ones) begin
                        if (deb == DW'(DEBOUNCE - 1)) begin
                            rel_n   = 1'b1;
                            held_n  = 1'b0;
                            cidx_n  = cidx_rot;
                            deb_n   = '0;
                            state_n = SCAN;
                        end else begin
                            deb_n = deb + DW'(1);
                        end
                    end else begin
                        deb_n   = '0;
                        state_n = PRESSED;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model, event scoreboard, vector table and
// hand-written corner sequences for keypad_scanner.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] keys = '0;
    logic [15:0] keys2 = '0;
    logic [3:0]  row, row2, col, col2;
    logic [3:0]  key_code, code2;
    logic        key_valid, key_held, key_release;
    logic        valid2, held2, rel2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int v_cnt = 0, r_cnt = 0, v2_cnt = 0, r2_cnt = 0;
    int exp_q[$];
    int v2_cyc[$];

    typedef struct {
        int key;
        int hold;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3),
        .REPEAT_DLY(0), .REPEAT_RATE(100)
    ) u_dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid),
        .key_held(key_held), .key_release(key_release)
    );

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3),
        .REPEAT_DLY(5), .REPEAT_RATE(2)
    ) u_rep (
        .clk(clk), .reset(reset), .row(row2), .col(col2),
        .key_code(code2), .key_valid(valid2),
        .key_held(held2), .key_release(rel2)
    );

    // physical keypad: a pressed key pulls its row low when its column is driven
    always_comb begin
        row  = '1;
        row2 = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
                if (keys2[c*4+r] && !col2[c]) row2[r] = 1'b0;
            end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int cnt_of(input int sel);
        case (sel)
            0:       return v_cnt;
            1:       return r_cnt;
            2:       return v2_cnt;
            default: return r2_cnt;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int sel,
                            input int target, input int budget);
        int n = 0;
        while (cnt_of(sel) < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, int'(cnt_of(sel) >= target), 1);
    endtask

    // event monitor and scoreboard
    always @(negedge clk) begin
        if (key_valid) begin
            v_cnt++;
            if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
            else chk("key_code", int'(key_code), exp_q.pop_front());
        end
        if (key_release) r_cnt++;
        if (key_valid && key_release) chk("valid_with_release", 1, 0);
        if (valid2) begin
            v2_cnt++;
            v2_cyc.push_back(cyc);
            chk("rep_code", int'(code2), 0);
        end
        if (rel2) r2_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev, exp_col, hold_col;
        int v0, r0, chg, k, n;
        int rep_off[5];
        rep_off = '{0, 20, 28, 36, 44};
        tbl[0] = '{9, 40};
        tbl[1] = '{0, 20};
        tbl[2] = '{5, 30};
        tbl[3] = '{15, 24};
        tbl[4] = '{12, 50};
        tbl[5] = '{3, 16};

        #2;
        chk("reset_outs", int'({col, key_code, key_valid, key_held, key_release}),
            int'({4'b1110, 4'd0, 3'b000}));
        #20 reset = 1'b1;

        // idle rotation and dwell
        prev    = col;
        exp_col = col;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (col == prev && n < 20) begin
                @(negedge clk);
                n++;
            end
            exp_col = {exp_col[2:0], exp_col[3]};
            chk("idle_col", int'(col), int'(exp_col));
            if (i > 0) chk("idle_dwell", n, 4);
            prev = col;
        end
        chk("idle_no_valid", v_cnt, 0);

        // vector table: press, hold, release
        for (int i = 0; i < 6; i++) begin
            v0 = v_cnt;
            r0 = r_cnt;
            exp_q.push_back(tbl[i].key);
            keys[tbl[i].key] = 1'b1;
            wait_for("press_valid", 0, v0 + 1, 200);
            chk("held_after_press", int'(key_held), 1);
            repeat (tbl[i].hold) @(negedge clk);
            #1;
            chk("single_valid", v_cnt, v0 + 1);
            keys = '0;
            wait_for("release_seen", 1, r0 + 1, 100);
            hold_col = 4'b1111;
            hold_col[(tbl[i].key / 4 + 1) % 4] = 1'b0;
            chk("rel_held", int'(key_held), 0);
            chk("rel_col_rotated", int'(col), int'(hold_col));
            chk("code_kept", int'(key_code), tbl[i].key);
            chk("rel_no_valid", v_cnt, v0 + 1);
        end

        // bounce on key 0: alternating samples never accepted
        v0   = v_cnt;
        chg  = 0;
        prev = col;
        for (k = 0; k < 24; k++) begin
            keys[0] = k[0];
            repeat (4) begin
                @(negedge clk);
                if (col != prev) begin
                    chg++;
                    prev = col;
                end
            end
        end
        keys = '0;
        chk("bounce_no_valid", v_cnt, v0);
        chk("bounce_rotates", int'(chg >= 12), 1);

        // ghost: two rows low on column 3
        keys[13] = 1'b1;
        keys[14] = 1'b1;
        chg  = 0;
        prev = col;
        repeat (96) begin
            @(negedge clk);
            if (col != prev) begin
                chg++;
                prev = col;
            end
        end
        keys = '0;
        chk("ghost_no_valid", v_cnt, v0);
        chk("ghost_rotates", int'(chg >= 12), 1);

        // release glitch and second key while held
        v0 = v_cnt;
        r0 = r_cnt;
        exp_q.push_back(6);
        keys[6] = 1'b1;
        wait_for("glitch_press", 0, v0 + 1, 200);
        repeat (8) @(negedge clk);
        keys[6] = 1'b0;
        repeat (6) @(negedge clk);
        keys[6] = 1'b1;
        repeat (20) @(negedge clk);
        keys[7] = 1'b1;
        repeat (12) @(negedge clk);
        keys[7] = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("glitch_no_release", r_cnt, r0);
        chk("glitch_no_valid", v_cnt, v0 + 1);
        chk("glitch_held", int'(key_held), 1);
        keys = '0;
        wait_for("glitch_release", 1, r0 + 1, 100);

        // reset while a key is held
        v0 = v_cnt;
        exp_q.push_back(10);
        keys[10] = 1'b1;
        wait_for("rst_press", 0, v0 + 1, 200);
        repeat (5) @(negedge clk);
        r0 = r_cnt;
        #3 reset = 1'b0;
        #1;
        chk("rst_outs", int'({col, key_code, key_valid, key_held, key_release}),
            int'({4'b1110, 4'd0, 3'b000}));
        repeat (6) @(negedge clk);
        #3 reset = 1'b1;
        exp_q.push_back(10);
        wait_for("rst_redetect", 0, v0 + 2, 200);
        chk("rst_no_release", r_cnt, r0);
        chk("rst_held_again", int'(key_held), 1);
        keys = '0;
        wait_for("rst_release", 1, r0 + 1, 100);

        // auto-repeat on the second instance
        keys2[0] = 1'b1;
        wait_for("rep_first", 2, 1, 200);
        wait_for("rep_fifth", 2, 5, 100);
        @(negedge clk);
        keys2 = '0;
        wait_for("rep_release", 3, 1, 100);
        chk("rep_count", v2_cnt, 5);
        for (int i = 0; i < 5; i++)
            if (i < v2_cyc.size())
                chk("rep_spacing", v2_cyc[i] - v2_cyc[0], rep_off[i]);
        chk("rep_held_clear", int'(held2), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
